// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning chain: repeat FSM
// encoding and default timing derived from the 100 MHz system clock.
`timescale 1ns/1ps
package btn_pkg;

  localparam int CLK_HZ              = 100000000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;
  localparam int DEF_REPEAT_RATE     = CLK_HZ / 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HOLD   = 2'd3
  } rpt_state_e;

  // One spare bit above the largest count so the counter can never wrap.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debouncer with glitch
// rejection, and the auto-repeat FSM that produces count strobes.
`timescale 1ns/1ps
module btn_channel
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic btn_release,
  output logic btn_event
);

  localparam int DBW     = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW     = cnt_width(RPT_MAX);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] DELAY_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RATE_LAST  = RPW'(REPEAT_RATE - 1);
  localparam logic           INACTIVE   = (ACTIVE_LOW != 0);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           rep_q, rep_d;
  logic [RPW-1:0] rcnt_q, rcnt_d;
  rpt_state_e     state_q, state_d;

  logic pressed;
  logic mismatch;
  logic db_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= INACTIVE;
      sync2_q   <= INACTIVE;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rep_q     <= 1'b0;
      rcnt_q    <= '0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      rep_q     <= rep_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  // Any cycle where the sample agrees with the accepted level restarts the count.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    pressed   = sync2_q ^ INACTIVE;
    mismatch  = (pressed != level_q);
    db_done   = mismatch && (db_cnt_q == DB_LAST);
    db_cnt_d  = (!mismatch || db_done) ? '0 : db_cnt_q + DBW'(1);
    level_d   = db_done ? ~level_q : level_q;
    press_d   = db_done && !level_q;
    release_d = db_done && level_q;
  end

  // Release takes priority over a due repeat so no strobe accompanies it.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_d) begin
          state_d = repeat_en ? DELAY : HOLD;
          rcnt_d  = '0;
        end
      end
      DELAY, REPEAT: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (!repeat_en) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end else if (rcnt_q == ((state_q == DELAY) ? DELAY_LAST : RATE_LAST)) begin
          state_d = REPEAT;
          rcnt_d  = '0;
          rep_d   = 1'b1;
        end else begin
          rcnt_d  = rcnt_q + RPW'(1);
        end
      end
      HOLD: begin
        if (release_d) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  assign level       = level_q;
  assign press       = press_q;
  assign btn_release = release_q;
  assign btn_event   = press_q | rep_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw push-button pins into clean levels, edge pulses and
// auto-repeat count strobes; one independent channel per button.
`timescale 1ns/1ps
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_Raw,
  input  logic [N_BTN-1:0] Repeat_En,
  output logic [N_BTN-1:0] Btn_Level,
  output logic [N_BTN-1:0] Btn_Press,
  output logic [N_BTN-1:0] Btn_Release,
  output logic [N_BTN-1:0] Btn_Event
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_chan (
      .clk         (Clk),
      .rst_n       (Reset),
      .btn_raw     (Btn_Raw[i]),
      .repeat_en   (Repeat_En[i]),
      .level       (Btn_Level[i]),
      .press       (Btn_Press[i]),
      .btn_release (Btn_Release[i]),
      .btn_event   (Btn_Event[i])
    );
  end

endmodule
